// File: rtl/cmd_cfg_ctrl.sv
// cmd_cfg_ctrl -- scope command decoder and configuration register bank.
// Decodes 24-bit UART commands {opcode,byte2,byte3}, drives the SPI master
// (trigger DAC, per-channel AFE gain, EEPROM), holds trigger/decimation/gain
// configuration and returns one response byte per command.  While idle the
// response port carries the gain/offset-corrected capture RAM sample.
// Optional feature: define CMD_RDBK_EN to enable opcode 0A (gain readback).
module cmd_cfg_ctrl #(
  parameter int NUM_CH     = 3,
  parameter int TRIG_POS_W = 9,
  parameter int DEC_W      = 4,
  parameter int SPI_TMO    = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [23:0]                   cmd,
  input  logic                          cmd_rdy,
  input  logic                          resp_sent,
  input  logic                          SPI_done,
  input  logic [7:0]                    EEP_data,
  input  logic [7:0]                    RAM_rdata,
  input  logic                          set_capture_done,
  input  logic                          flopGain,
  input  logic                          flopOffset,
  output logic                          clr_cmd_rdy,
  output logic                          send_resp,
  output logic [7:0]                    resp_data,
  output logic                          wrt_SPI,
  output logic [15:0]                   SPI_data,
  output logic [$clog2(NUM_CH+2)-1:0]   ss,
  output logic                          dump,
  output logic [1:0]                    dump_ch,
  output logic [7:0]                    trig_cfg,
  output logic [TRIG_POS_W-1:0]         trig_pos,
  output logic [DEC_W-1:0]              decimator,
  output logic [3*NUM_CH-1:0]           ch_AFEgain
);

  localparam int SS_W  = $clog2(NUM_CH+2);
  localparam int CNT_W = $clog2(SPI_TMO);

  localparam logic [7:0] OP_DUMP_CH  = 8'h01;
  localparam logic [7:0] OP_CFG_GAIN = 8'h02;
  localparam logic [7:0] OP_TRIG_LVL = 8'h03;
  localparam logic [7:0] OP_TRIG_POS = 8'h04;
  localparam logic [7:0] OP_SET_DEC  = 8'h05;
  localparam logic [7:0] OP_TRIG_CFG = 8'h06;
  localparam logic [7:0] OP_RD_TCFG  = 8'h07;
  localparam logic [7:0] OP_EEP_WRT  = 8'h08;
  localparam logic [7:0] OP_EEP_RD   = 8'h09;
  localparam logic [7:0] OP_RD_GAIN  = 8'h0A;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam logic [7:0] RESP_ERR  = 8'hEE;
  localparam logic [7:0] RESP_TMO  = 8'hEF;
  localparam logic [7:0] SPI_WRCMD = 8'h13;
  localparam logic [2:0] NUM_CH_L  = 3'(NUM_CH);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    SPI_WAIT,
    EEP_WAIT,
    RESP_WAIT
  } state_t;

  state_t           state;
  logic [23:0]      cmd_reg;
  logic [7:0]       resp_q;
  logic [7:0]       gain_coef;
  logic [7:0]       offset_coef;
  logic [CNT_W-1:0] tmo_cnt;

  logic [7:0]       opcode;
  logic [1:0]       cc;
  logic             cc_valid;
  logic             lvl_valid;
  logic             tmo_hit;
  logic [2:0]       rdbk_gain;
  logic [7:0]       corrected;
  logic signed [9:0] sum_ext;
  logic [7:0]       sum_clip;
  logic [15:0]      prod;
  logic             unused_bits;

  assign opcode      = cmd_reg[23:16];
  assign cc          = cmd_reg[9:8];
  assign cc_valid    = ({1'b0, cc} < NUM_CH_L);
  assign lvl_valid   = (cmd_reg[7:0] >= 8'd46) && (cmd_reg[7:0] <= 8'd201);
  assign tmo_hit     = (tmo_cnt == CNT_W'(SPI_TMO-1));
  assign unused_bits = ^cmd_reg[15:14];

  // AFE gain code to DAC setting lookup
  function automatic logic [7:0] afe_lut(input logic [2:0] g);
    case (g)
      3'd0:    afe_lut = 8'h02;
      3'd1:    afe_lut = 8'h05;
      3'd2:    afe_lut = 8'h09;
      3'd3:    afe_lut = 8'h14;
      3'd4:    afe_lut = 8'h28;
      3'd5:    afe_lut = 8'h46;
      3'd6:    afe_lut = 8'h6B;
      default: afe_lut = 8'hDD;
    endcase
  endfunction

  // Select the stored gain code of the addressed channel for readback
  always_comb begin
    rdbk_gain = 3'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cc == 2'(i)) rdbk_gain = ch_AFEgain[3*i +: 3];
    end
  end

  // Gain corrector: signed offset added and clipped to 0..255, then scaled
  // by the gain coefficient in 1.7 fixed point and clipped to 255
  always_comb begin
    sum_ext = $signed({2'b00, RAM_rdata}) + $signed({{2{offset_coef[7]}}, offset_coef});
    if (sum_ext < 10'sd0)
      sum_clip = 8'h00;
    else if (sum_ext > 10'sd255)
      sum_clip = 8'hFF;
    else
      sum_clip = sum_ext[7:0];
    prod      = sum_clip * gain_coef;
    corrected = prod[15] ? 8'hFF : prod[14:7];
  end

  // Idle shows the live corrected sample, otherwise the latched response
  assign resp_data = (state == IDLE) ? corrected : resp_q;

  // Command FSM with all configuration registers and registered pulse outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd_reg     <= 24'h0;
      resp_q      <= 8'h00;
      gain_coef   <= 8'h00;
      offset_coef <= 8'h00;
      tmo_cnt     <= '0;
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
      wrt_SPI     <= 1'b0;
      dump        <= 1'b0;
      SPI_data    <= 16'h0000;
      ss          <= SS_W'(NUM_CH+1);
      dump_ch     <= 2'd0;
      trig_cfg    <= 8'h20;
      trig_pos    <= '0;
      decimator   <= '0;
      ch_AFEgain  <= '0;
    end else begin
      clr_cmd_rdy <= 1'b0;
      send_resp   <= 1'b0;
      wrt_SPI     <= 1'b0;
      dump        <= 1'b0;

      if (flopGain)   gain_coef   <= EEP_data;
      if (flopOffset) offset_coef <= EEP_data;

      case (state)
        IDLE: begin
          if (cmd_rdy) begin
            cmd_reg <= cmd;
            state   <= DECODE;
          end
        end

        DECODE: begin
          resp_q    <= RESP_ERR;
          send_resp <= 1'b1;
          state     <= RESP_WAIT;
          case (opcode)
            OP_DUMP_CH: begin
              if (cc_valid) begin
                send_resp   <= 1'b0;
                dump        <= 1'b1;
                dump_ch     <= cc;
                clr_cmd_rdy <= 1'b1;
                state       <= IDLE;
              end
            end
            OP_CFG_GAIN: begin
              if (cc_valid) begin
                for (int i = 0; i < NUM_CH; i++) begin
                  if (cc == 2'(i)) ch_AFEgain[3*i +: 3] <= cmd_reg[12:10];
                end
                ss        <= SS_W'(32'(cc) + 1);
                SPI_data  <= {SPI_WRCMD, afe_lut(cmd_reg[12:10])};
                wrt_SPI   <= 1'b1;
                tmo_cnt   <= '0;
                send_resp <= 1'b0;
                state     <= SPI_WAIT;
              end
            end
            OP_TRIG_LVL: begin
              if (lvl_valid) begin
                ss        <= '0;
                SPI_data  <= {SPI_WRCMD, cmd_reg[7:0]};
                wrt_SPI   <= 1'b1;
                tmo_cnt   <= '0;
                send_resp <= 1'b0;
                state     <= SPI_WAIT;
              end
            end
            OP_TRIG_POS: begin
              trig_pos <= cmd_reg[TRIG_POS_W-1:0];
              resp_q   <= RESP_ACK;
            end
            OP_SET_DEC: begin
              decimator <= cmd_reg[DEC_W-1:0];
              resp_q    <= RESP_ACK;
            end
            OP_TRIG_CFG: begin
              if (!cmd_reg[9]) begin
                trig_cfg <= {2'b00, cmd_reg[13:8]};
                resp_q   <= RESP_ACK;
              end
            end
            OP_RD_TCFG: begin
              resp_q <= trig_cfg;
            end
            OP_EEP_WRT: begin
              ss        <= SS_W'(NUM_CH+1);
              SPI_data  <= {2'b01, cmd_reg[13:0]};
              wrt_SPI   <= 1'b1;
              tmo_cnt   <= '0;
              send_resp <= 1'b0;
              state     <= SPI_WAIT;
            end
            OP_EEP_RD: begin
              ss        <= SS_W'(NUM_CH+1);
              SPI_data  <= {2'b00, cmd_reg[13:0]};
              wrt_SPI   <= 1'b1;
              tmo_cnt   <= '0;
              send_resp <= 1'b0;
              state     <= EEP_WAIT;
            end
`ifdef CMD_RDBK_EN
            OP_RD_GAIN: begin
              if (cc_valid) resp_q <= {5'b00000, rdbk_gain};
            end
`endif
            default: ;
          endcase
        end

        SPI_WAIT: begin
          if (SPI_done) begin
            resp_q    <= (opcode == OP_EEP_RD) ? EEP_data : RESP_ACK;
            send_resp <= 1'b1;
            state     <= RESP_WAIT;
          end else if (tmo_hit) begin
            resp_q    <= RESP_TMO;
            send_resp <= 1'b1;
            state     <= RESP_WAIT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        EEP_WAIT: begin
          if (SPI_done) begin
            SPI_data <= 16'h0000;
            wrt_SPI  <= 1'b1;
            tmo_cnt  <= '0;
            state    <= SPI_WAIT;
          end else if (tmo_hit) begin
            resp_q    <= RESP_TMO;
            send_resp <= 1'b1;
            state     <= RESP_WAIT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        RESP_WAIT: begin
          if (resp_sent) begin
            clr_cmd_rdy <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      if (set_capture_done) trig_cfg[5] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_cfg_ctrl.sv
// tb_cmd_cfg_ctrl -- directed self-checking bench for cmd_cfg_ctrl.
// Acts as UART wrapper and SPI master around the DUT; expected values are
// hand-computed constants.  Compile with CMD_RDBK_EN defined to cover 0A.
module tb_cmd_cfg_ctrl;

  localparam int NUM_CH = 3;
  localparam int TMO    = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] cmd = 24'h0;
  logic        cmd_rdy = 1'b0;
  logic        resp_sent = 1'b0;
  logic        SPI_done = 1'b0;
  logic [7:0]  EEP_data = 8'h00;
  logic [7:0]  RAM_rdata = 8'h00;
  logic        set_capture_done = 1'b0;
  logic        flopGain = 1'b0;
  logic        flopOffset = 1'b0;
  logic        clr_cmd_rdy, send_resp, wrt_SPI, dump;
  logic [7:0]  resp_data, trig_cfg;
  logic [15:0] SPI_data;
  logic [2:0]  ss;
  logic [1:0]  dump_ch;
  logic [8:0]  trig_pos;
  logic [3:0]  decimator;
  logic [8:0]  ch_AFEgain;

  cmd_cfg_ctrl #(.NUM_CH(NUM_CH), .TRIG_POS_W(9), .DEC_W(4), .SPI_TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp_sent(resp_sent),
    .SPI_done(SPI_done), .EEP_data(EEP_data), .RAM_rdata(RAM_rdata),
    .set_capture_done(set_capture_done), .flopGain(flopGain), .flopOffset(flopOffset),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp_data(resp_data),
    .wrt_SPI(wrt_SPI), .SPI_data(SPI_data), .ss(ss), .dump(dump), .dump_ch(dump_ch),
    .trig_cfg(trig_cfg), .trig_pos(trig_pos), .decimator(decimator),
    .ch_AFEgain(ch_AFEgain)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Pulse monitor: counts and captures DUT pulses on every falling edge
  int          cyc = 0, nResp = 0, nWrt = 0, nClr = 0, nDump = 0;
  int          lastWrtCyc = 0, lastRespCyc = 0;
  logic [7:0]  lastResp = 8'h00;
  logic [15:0] lastSpi = 16'h0, prevSpi = 16'h0;
  logic [2:0]  lastSs = 3'd0;

  always @(negedge clk) begin
    cyc++;
    if (send_resp) begin
      nResp++;
      lastResp    = resp_data;
      lastRespCyc = cyc;
    end
    if (wrt_SPI) begin
      nWrt++;
      prevSpi    = lastSpi;
      lastSpi    = SPI_data;
      lastSs     = ss;
      lastWrtCyc = cyc;
    end
    if (clr_cmd_rdy) nClr++;
    if (dump) nDump++;
  end

  int dResp, dWrt, dClr, dDump;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and play UART/SPI partner until clr_cmd_rdy;
  // ackDelay = clocks from wrt_SPI to SPI_done (0 = never answer)
  task automatic applyStimulus(input logic [23:0] c, input int ackDelay);
    int r0, w0, c0, d0, spiPend, respPend;
    bit done;
    r0 = nResp; w0 = nWrt; c0 = nClr; d0 = nDump;
    spiPend = 0; respPend = 0; done = 1'b0;
    @(negedge clk);
    cmd = c;
    cmd_rdy = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      SPI_done = 1'b0;
      resp_sent = 1'b0;
      if (clr_cmd_rdy) begin
        cmd_rdy = 1'b0;
        done = 1'b1;
      end
      if (wrt_SPI) spiPend = ackDelay;
      else if (spiPend > 0) begin
        spiPend--;
        if (spiPend == 0) SPI_done = 1'b1;
      end
      if (send_resp) respPend = 2;
      else if (respPend > 0) begin
        respPend--;
        if (respPend == 0) resp_sent = 1'b1;
      end
    end
    checkOutput($sformatf("done_%06h", c), 32'(done), 32'd1);
    cmd_rdy = 1'b0;
    SPI_done = 1'b0;
    resp_sent = 1'b0;
    @(negedge clk);
    dResp = nResp - r0; dWrt = nWrt - w0; dClr = nClr - c0; dDump = nDump - d0;
  endtask

  int r0;
  logic [7:0] rdbkExp;

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    // reset values
    checkOutput("rst_trig_cfg", 32'(trig_cfg), 32'h20);
    checkOutput("rst_trig_pos", 32'(trig_pos), 32'h0);
    checkOutput("rst_dec", 32'(decimator), 32'h0);
    checkOutput("rst_gain", 32'(ch_AFEgain), 32'h0);
    checkOutput("rst_ss", 32'(ss), 32'd4);
    checkOutput("rst_spi", 32'(SPI_data), 32'h0);
    checkOutput("rst_resp", 32'(resp_data), 32'h0);
    checkOutput("rst_pulses", 32'({send_resp, wrt_SPI, clr_cmd_rdy, dump}), 32'h0);
    rst_n = 1'b1;

    // gain corrector on idle response path
    @(negedge clk); EEP_data = 8'h80; flopGain = 1'b1;
    @(negedge clk); flopGain = 1'b0; EEP_data = 8'h05; flopOffset = 1'b1;
    @(negedge clk); flopOffset = 1'b0; RAM_rdata = 8'h10;
    @(negedge clk); checkOutput("corr_basic", 32'(resp_data), 32'h15);
    RAM_rdata = 8'hFE;
    @(negedge clk); checkOutput("corr_sumsat", 32'(resp_data), 32'hFF);
    EEP_data = 8'hF0; flopOffset = 1'b1;
    @(negedge clk); flopOffset = 1'b0; RAM_rdata = 8'h08;
    @(negedge clk); checkOutput("corr_neg", 32'(resp_data), 32'h00);
    RAM_rdata = 8'hFE;
    @(negedge clk); checkOutput("corr_negoff", 32'(resp_data), 32'hEE);
    EEP_data = 8'hFF; flopGain = 1'b1; RAM_rdata = 8'hFF;
    @(negedge clk); flopGain = 1'b0;
    @(negedge clk); checkOutput("corr_prodsat", 32'(resp_data), 32'hFF);

    // trig_cfg write and capture-done set
    applyStimulus(24'h060000, 0);
    checkOutput("tcfg_val", 32'(trig_cfg), 32'h00);
    checkOutput("tcfg_resp", 32'(lastResp), 32'hA5);
    checkOutput("tcfg_clr", 32'(dClr), 32'd1);
    set_capture_done = 1'b1;
    @(negedge clk); set_capture_done = 1'b0;
    checkOutput("capdone", 32'(trig_cfg), 32'h20);
    applyStimulus(24'h060A00, 0);
    checkOutput("tcfg_bad", 32'(lastResp), 32'hEE);
    checkOutput("tcfg_keep", 32'(trig_cfg), 32'h20);

    // capture-done coincident with a trig_cfg write
    @(negedge clk); cmd = 24'h060500; cmd_rdy = 1'b1;
    @(negedge clk); set_capture_done = 1'b1;
    @(negedge clk); set_capture_done = 1'b0;
    checkOutput("cap_prio", 32'(trig_cfg), 32'h25);
    checkOutput("cap_send", 32'(send_resp), 32'd1);
    resp_sent = 1'b1;
    @(negedge clk); resp_sent = 1'b0;
    checkOutput("cap_clr", 32'(clr_cmd_rdy), 32'd1);
    cmd_rdy = 1'b0;
    applyStimulus(24'h070000, 0);
    checkOutput("rd_tcfg", 32'(lastResp), 32'h25);

    // dump: pulses exactly two clocks after cmd_rdy
    @(negedge clk); cmd = 24'h010200; cmd_rdy = 1'b1;
    @(negedge clk); checkOutput("dump_early", 32'(dump), 32'd0);
    @(negedge clk);
    checkOutput("dump_pulse", 32'(dump), 32'd1);
    checkOutput("dump_clr", 32'(clr_cmd_rdy), 32'd1);
    checkOutput("dump_ch", 32'(dump_ch), 32'd2);
    cmd_rdy = 1'b0;
    @(negedge clk); checkOutput("dump_once", 32'(dump), 32'd0);
    applyStimulus(24'h010300, 0);
    checkOutput("dump_badcc", 32'(lastResp), 32'hEE);
    checkOutput("dump_badnone", 32'(dDump), 32'd0);

    // AFE gain configuration
    applyStimulus(24'h021600, 3);
    checkOutput("gain2_spi", 32'(lastSpi), 32'h1346);
    checkOutput("gain2_ss", 32'(lastSs), 32'd3);
    checkOutput("gain2_reg", 32'(ch_AFEgain[8:6]), 32'd5);
    checkOutput("gain2_resp", 32'(lastResp), 32'hA5);
    applyStimulus(24'h020C00, 3);
    checkOutput("gain0_spi", 32'(lastSpi), 32'h1314);
    checkOutput("gain0_ss", 32'(lastSs), 32'd1);
    applyStimulus(24'h021D00, 3);
    checkOutput("gain1_spi", 32'(lastSpi), 32'h13DD);
    checkOutput("gain_all", 32'(ch_AFEgain), 32'h17B);
    applyStimulus(24'h020300, 3);
    checkOutput("gain_badcc", 32'(lastResp), 32'hEE);
    checkOutput("gain_badspi", 32'(dWrt), 32'd0);

    // trigger level window boundaries
    applyStimulus(24'h03002D, 3);
    checkOutput("lvl_low", 32'(lastResp), 32'hEE);
    applyStimulus(24'h03002E, 3);
    checkOutput("lvl_min", 32'(lastSpi), 32'h132E);
    applyStimulus(24'h0300C9, 3);
    checkOutput("lvl_max", 32'(lastSpi), 32'h13C9);
    checkOutput("lvl_ss", 32'(lastSs), 32'd0);
    applyStimulus(24'h0300CA, 3);
    checkOutput("lvl_high", 32'(lastResp), 32'hEE);
    checkOutput("lvl_highspi", 32'(dWrt), 32'd0);

    // trig_pos / decimator
    applyStimulus(24'h0401FF, 0);
    checkOutput("tpos", 32'(trig_pos), 32'h1FF);
    checkOutput("tpos_resp", 32'(lastResp), 32'hA5);
    applyStimulus(24'h05001B, 0);
    checkOutput("dec", 32'(decimator), 32'hB);

    // EEPROM read: address write then dummy read word
    EEP_data = 8'h5A;
    applyStimulus(24'h090005, 3);
    checkOutput("eeprd_nwrt", 32'(dWrt), 32'd2);
    checkOutput("eeprd_w1", 32'(prevSpi), 32'h0005);
    checkOutput("eeprd_w2", 32'(lastSpi), 32'h0000);
    checkOutput("eeprd_ss", 32'(lastSs), 32'd4);
    checkOutput("eeprd_resp", 32'(lastResp), 32'h5A);
    checkOutput("eeprd_clr", 32'(dClr), 32'd1);

    // EEPROM write timeout, SPI_done arriving one clock too late
    applyStimulus(24'h080122, TMO + 1);
    checkOutput("tmo_spi", 32'(lastSpi), 32'h4122);
    checkOutput("tmo_resp", 32'(lastResp), 32'hEF);
    checkOutput("tmo_lat", 32'(lastRespCyc - lastWrtCyc), 32'(TMO));
    checkOutput("tmo_nresp", 32'(dResp), 32'd1);

    // optional gain readback / unknown opcode
`ifdef CMD_RDBK_EN
    rdbkExp = 8'h07;
`else
    rdbkExp = 8'hEE;
`endif
    applyStimulus(24'h0A0100, 0);
    checkOutput("rdbk", 32'(lastResp), 32'(rdbkExp));
    applyStimulus(24'h330000, 0);
    checkOutput("bad_op", 32'(lastResp), 32'hEE);

    // reset in the middle of an SPI wait
    @(negedge clk); cmd = 24'h080122; cmd_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk); cmd_rdy = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    r0 = nResp;
    @(negedge clk);
    checkOutput("mrst_tcfg", 32'(trig_cfg), 32'h20);
    checkOutput("mrst_pulses", 32'({send_resp, wrt_SPI, clr_cmd_rdy, dump}), 32'h0);
    checkOutput("mrst_ss", 32'(ss), 32'd4);
    checkOutput("mrst_gain", 32'(ch_AFEgain), 32'h0);
    rst_n = 1'b1;
    repeat (TMO + 10) @(negedge clk);
    checkOutput("mrst_noresp", 32'(nResp - r0), 32'd0);
    applyStimulus(24'h070000, 0);
    checkOutput("mrst_rd", 32'(lastResp), 32'h20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
